ahbl_apb_bridge_mslot: RTL
==========================

Name: ahbl_apb_bridge_mslot

Overview:
- Parametrised AHB-Lite slave to APB3 master bridge for the BFM and CoreUART subsystems.
- Successor to the fixed single-configuration bridge. Adds:
  - configurable slot count and slot-field position;
  - PSLVERR-to-HRESP two-cycle error signalling;
  - error response for unmapped slots;
  - an optional PREADY watchdog timeout.
- Sits between the AHB-Lite fabric (HSEL slot) and up to 16 APB peripherals. The APB side runs on HCLK.

Parameters:
- NUM_SLAVES, 16, number of PSEL outputs (1..16).
- ADDR_WIDTH, 32, width of HADDR/PADDR (>= SLOT_LSB+4).
- SLOT_LSB, 8, LSB of the 4-bit slot field in HADDR.
- TIMEOUT_CYCLES, 0, max ACCESS cycles waiting on PREADY; 0 disables the watchdog.

Ports:
- HCLK  in  1  clock; also the APB clock.
- HRESETN  in  1  asynchronous active-low reset.
- HSEL  in  1  bridge select.
- HADDR  in  ADDR_WIDTH  AHB address.
- HWRITE  in  1  AHB write.
- HTRANS  in  2  AHB transfer type.
- HSIZE  in  3  AHB size; ignored, all APB accesses are 32-bit.
- HWDATA  in  32  AHB write data.
- HREADYIN  in  1  fabric ready.
- HRDATA  out  32  read data to AHB.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  1  1 = ERROR.
- PSEL  out  NUM_SLAVES  one-hot APB select.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB write.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  muxed APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clocking/reset: one clock, HCLK. Reset is asynchronous and active-low on HRESETN.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HRDATA=0, HREADYOUT=1, HRESP=0, state=IDLE, watchdog=0.
- Reset asserted mid-transfer forces all reset values immediately. No APB completion is reported.
- Transfer accept: in IDLE or ERR2, on a rising edge with HSEL & HREADYIN & HTRANS[1] = 1.
  - Latch HADDR, HWRITE and slot = HADDR[SLOT_LSB+3:SLOT_LSB].
  - slot < NUM_SLAVES: go to SETUP.
  - Otherwise (unmapped slot): go to ERR1. No PSEL is asserted.
- Idle/busy: HSEL with HTRANS = IDLE/BUSY gets a zero-wait OKAY. HREADYOUT stays 1.
- States:
  - IDLE: no APB activity.
  - SETUP: PSEL[slot]=1, PENABLE=0, PADDR=latched address, PWRITE=latched write. PWDATA=HWDATA, registered at the end of SETUP. HREADYOUT=0. Always 1 cycle, then ACCESS.
  - ACCESS: PSEL held, PENABLE=1, PWDATA held from the register, HREADYOUT=0. Stays while PREADY=0.
    - PREADY=1, PSLVERR=0: go to IDLE. Next cycle HREADYOUT=1, HRESP=0. HRDATA<=PRDATA on reads only; writes leave HRDATA unchanged.
    - PREADY=1, PSLVERR=1: go to ERR1. HRDATA is not updated.
  - ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts a new transfer exactly as IDLE does; otherwise returns to IDLE.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - Reaching TIMEOUT_CYCLES forces ERR1 and drops PSEL/PENABLE.
  - A PREADY seen on the timeout cycle itself is ignored.
- Latency: zero-wait APB gives address phase A; SETUP in A+1, ACCESS in A+2, HREADYOUT=1 in A+3. Each PREADY wait state adds 1 cycle.
- Pipelining: an address phase presented while HREADYOUT=1 (IDLE or ERR2) is accepted. Back-to-back transfers have no dead cycle beyond SETUP.
- PADDR/PWRITE hold their last values in IDLE. PSEL is never multi-hot.

Test Plan:
- Write to 0x0000_0104 of 0xDEADBEEF, PREADY=1 → SETUP with PSEL[1], then ACCESS with PWDATA=0xDEADBEEF; HREADYOUT=1 at A+3; HRESP=0.
- Read from 0x0000_0304, PREADY low for 2 ACCESS cycles, PRDATA=0x12345678 → HREADYOUT low 4 cycles; HRDATA=0x12345678.
- Write to slot 2 with PSLVERR=1 on the PREADY cycle → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE with HRESP=0.
- NUM_SLAVES=4, access 0x0000_0500 → no PSEL pulse; two-cycle ERROR starts the cycle after the address phase.
- TIMEOUT_CYCLES=8, PREADY held 0 → PSEL/PENABLE drop after 8 ACCESS cycles; two-cycle ERROR follows.
- Back-to-back read slot 0 then write slot 3, then HRESETN pulsed low during the second ACCESS → second transfer issues with no extra idle; on reset, all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahbl_apb_bridge_mslot.sv
// AHB-Lite slave to APB3 master bridge with configurable slot decode, a two-cycle
// ERROR response for PSLVERR/unmapped slots, and an optional PREADY watchdog.
module ahbl_apb_bridge_mslot #(
  parameter int unsigned NUM_SLAVES     = 16,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SLOT_LSB       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // The watchdog only ever needs to reach TIMEOUT_CYCLES-1: that value marks the last ACCESS cycle.
  localparam int unsigned    WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                  state_q,  state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,  paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [3:0]              slot_q,   slot_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic [31:0]             hrdata_q, hrdata_d;
  logic [WD_W-1:0]         wdog_q,   wdog_d;

  logic                    accept;
  logic [3:0]              addr_slot;
  logic                    slot_mapped;
  logic                    timeout;
  logic                    unused_ok;

  assign accept      = HSEL & HREADYIN & HTRANS[1];
  assign addr_slot   = HADDR[SLOT_LSB +: 4];
  assign slot_mapped = ({1'b0, addr_slot} < 5'(NUM_SLAVES));
  assign timeout     = (TIMEOUT_CYCLES > 0) && (wdog_q == WD_LAST);
  assign unused_ok   = ^{HSIZE, HTRANS[0]};

  // NOTE: every _d gets its _q value first so no path through the case leaves a latch.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    slot_d   = slot_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    wdog_d   = wdog_q;

    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          slot_d   = addr_slot;
          state_d  = slot_mapped ? ST_SETUP : ST_ERR1;
        end
      end
      ST_SETUP: begin
        pwdata_d = HWDATA;
        wdog_d   = '0;
        state_d  = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A timeout wins over a PREADY arriving in the same cycle.
        if (timeout) begin
          state_d = ST_ERR1;
        end else if (PREADY) begin
          if (PSLVERR) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_IDLE;
            if (!pwrite_q) hrdata_d = PRDATA;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      slot_q   <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      slot_q   <= slot_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      wdog_q   <= wdog_d;
    end
  end

  // Outputs decode from state so an asynchronous reset clears them immediately.
  assign PSEL      = (state_q == ST_SETUP || state_q == ST_ACCESS)
                     ? (NUM_SLAVES'(1) << slot_q) : '0;
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = (state_q == ST_SETUP) ? HWDATA : pwdata_q;
  assign HRDATA    = hrdata_q;
  assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

endmodule
